// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, PMOD pin map, receiver state type
// and the CRC-16-CCITT byte step used by the optional frame CRC (FRAME_CRC_EN).
package vga_timing_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

    localparam int PMOD_R1    = 0;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_HSYNC = 7;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // MSB-first, unreflected, poly 0x1021
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc_in,
                                                     input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_input_sync.sv
// vga_input_sync: synchronizes the PMOD byte, detects falling sync edges and presents
// the colour bits of the same sample the edge pulses refer to.
module vga_input_sync
    import vga_timing_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] vga_in,
    output logic       hsync_fall,
    output logic       vsync_fall,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sample;
    logic       hsync_prev;
    logic       vsync_prev;

    // Syncs reset low so an idle-high input never produces a spurious fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hsync_prev <= 1'b0;
            vsync_prev <= 1'b0;
        end else begin
            sync_q[0] <= vga_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hsync_prev <= sample[PMOD_HSYNC];
            vsync_prev <= sample[PMOD_VSYNC];
        end
    end

    assign sample     = sync_q[SYNC_STAGES-1];
    assign hsync_fall = hsync_prev & ~sample[PMOD_HSYNC];
    assign vsync_fall = vsync_prev & ~sample[PMOD_VSYNC];
    assign r          = {sample[PMOD_R1], sample[PMOD_R0]};
    assign g          = {sample[PMOD_G1], sample[PMOD_G0]};
    assign b          = {sample[PMOD_B1], sample[PMOD_B0]};

endmodule

// File: rtl/vga_pmod_receiver.sv
// vga_pmod_receiver: recovers 640x480@60 position, colour and lock from a Tiny VGA PMOD byte.
// Define FRAME_CRC_EN to add a per-frame CRC-16-CCITT of the visible pixels (crc, crc_valid).
//
// state  | meaning
// SEARCH | counting consecutive good lines, waiting for a vsync fall to lock
// LOCKED | timing trusted; counting missed/misaligned hsyncs
module vga_pmod_receiver
    import vga_timing_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_LINES  = 4,
    parameter int MISS_LIMIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        display_on,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        locked,
    output logic        frame_start
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] crc,
    output logic        crc_valid
`endif
);

    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_LINES);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_PRE_SYNC = 10'(H_SYNC_START - 1);
    localparam logic [9:0] H_LOAD     = 10'(H_SYNC_START);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_LOAD     = 10'(V_SYNC_START);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);

    logic        hsync_fall, vsync_fall;
    logic [1:0]  r_in, g_in, b_in;
    logic [9:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [5:0]  rgb_q;
    lock_state_t state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic        line_wrap, good_line, bad_line, missed;

    vga_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk        (clk),
        .reset      (reset),
        .vga_in     (vga_in),
        .hsync_fall (hsync_fall),
        .vsync_fall (vsync_fall),
        .r          (r_in),
        .g          (g_in),
        .b          (b_in)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            rgb_q   <= '0;
            state_q <= SEARCH;
            good_q  <= '0;
            miss_q  <= '0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            rgb_q   <= {r_in, g_in, b_in};
            state_q <= state_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        hpos_d    = (hpos_q == H_LAST) ? '0 : hpos_q + 10'd1;
        line_wrap = 1'b0;
        if (hsync_fall)
            hpos_d = H_LOAD;
        else
            line_wrap = (hpos_q == H_LAST);

        vpos_d = vpos_q;
        if (vsync_fall)
            vpos_d = V_LOAD;
        else if (line_wrap)
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;

        good_line = hsync_fall && (hpos_q == H_PRE_SYNC);
        bad_line  = hsync_fall && !good_line;
        // The counter reaching 656 on its own means the expected hsync never came.
        missed    = bad_line || (!hsync_fall && (hpos_q == H_PRE_SYNC));

        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        case (state_q)
            SEARCH: begin
                if (good_line && (good_q < LOCK_MAX))
                    good_d = good_q + GW'(1);
                else if (bad_line)
                    good_d = '0;
                if (vsync_fall && (good_q >= LOCK_MAX)) begin
                    state_d = LOCKED;
                    miss_d  = '0;
                end
            end
            LOCKED: begin
                if (missed) begin
                    if (miss_q + MW'(1) >= MISS_MAX) begin
                        state_d = SEARCH;
                        good_d  = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MW'(1);
                    end
                end else if (good_line) begin
                    miss_d = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign locked      = (state_q == LOCKED);
    assign display_on  = locked && (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign r           = display_on ? rgb_q[5:4] : 2'b00;
    assign g           = display_on ? rgb_q[3:2] : 2'b00;
    assign b           = display_on ? rgb_q[1:0] : 2'b00;
    assign frame_start = locked && (hpos_q == '0) && (vpos_q == '0);

`ifdef FRAME_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d;
    logic        last_pixel;

    always_comb begin
        crc_acc_d = crc_acc_q;
        if (display_on)
            crc_acc_d = crc16_ccitt_byte(frame_start ? 16'hFFFF : crc_acc_q, {2'b00, r, g, b});
    end

    assign last_pixel = display_on && (hpos_q == H_VIS - 10'd1) && (vpos_q == V_VIS - 10'd1);

    // Latch on the last visible pixel so crc is valid alongside the crc_valid pulse at hpos=640.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_acc_q <= 16'hFFFF;
            crc       <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_acc_q <= crc_acc_d;
            crc_valid <= last_pixel;
            if (last_pixel)
                crc <= crc_acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_vga_pmod_receiver.sv
// tb_vga_pmod_receiver: drives a 640x480 PMOD generator (random colours) into the receiver
// and compares every output cycle with a pixel-level reference model of the recovery rules.
`timescale 1ns/1ps
module tb_vga_pmod_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_LINES  = 4;
    localparam int MISS_LIMIT  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vga_in = 8'h00;
    logic [9:0] hpos, vpos;
    logic       display_on, locked, frame_start;
    logic [1:0] r, g, b;
`ifdef FRAME_CRC_EN
    logic [15:0] crc;
    logic        crc_valid;
`endif

    always #5 clk = ~clk;

    vga_pmod_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_LINES  (LOCK_LINES),
        .MISS_LIMIT  (MISS_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vga_in      (vga_in),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .r           (r),
        .g           (g),
        .b           (b),
        .locked      (locked),
        .frame_start (frame_start)
`ifdef FRAME_CRC_EN
        ,
        .crc         (crc),
        .crc_valid   (crc_valid)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- transmitter ----------------
    int tx_h = 0, tx_v = 0, line_len = 800;
    bit hs_off = 1'b0;

    function automatic logic [7:0] tx_byte();
        logic [1:0] cr, cg, cb;
        logic hs, vs;
        hs = !(tx_h >= 656 && tx_h < 752) || hs_off;
        vs = !(tx_v >= 490 && tx_v < 492);
        if (tx_h < 640 && tx_v < 480) begin
            if (tx_h == 100 && tx_v == 1) {cr, cg, cb} = {2'd3, 2'd1, 2'd2};
            else                          {cr, cg, cb} = 6'($urandom);
        end else begin
            {cr, cg, cb} = 6'd0;
        end
        return {hs, cb[0], cg[0], cr[0], vs, cb[1], cg[1], cr[1]};
    endfunction

    task automatic tx_advance();
        tx_h++;
        if (tx_h == line_len) begin
            tx_h = 0;
            tx_v = (tx_v + 1) % 525;
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] pipe [$];
    int  mh, mv, gc, mc;
    bit  ml, m_prev_hs, m_prev_vs;
    logic [7:0] m_pix;
    int  fs_seen = 0;
`ifdef FRAME_CRC_EN
    logic [15:0] m_acc, m_crc;
    bit          m_crc_valid;

    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        for (int k = 0; k < 8; k++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction
`endif

    function automatic logic [5:0] pix_rgb(input logic [7:0] p);
        return {p[0], p[4], p[1], p[5], p[2], p[6]};
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; gc = 0; mc = 0; ml = 1'b0;
        m_prev_hs = 1'b0; m_prev_vs = 1'b0; m_pix = 8'h00;
        pipe.delete();
        repeat (SYNC_STAGES) pipe.push_back(8'h00);
`ifdef FRAME_CRC_EN
        m_acc = 16'hFFFF; m_crc = 16'h0000; m_crc_valid = 1'b0;
`endif
    endtask

    task automatic model_step(input logic [7:0] pin);
        logic [7:0] cur;
        bit hsf, vsf, good, miss, lock_now;
        int oh;
`ifdef FRAME_CRC_EN
        bit pre_disp;
        pre_disp = ml && mh < 640 && mv < 480;
        if (pre_disp) begin
            if (mh == 0 && mv == 0) m_acc = 16'hFFFF;
            m_acc = crc_ref(m_acc, {2'b00, pix_rgb(m_pix)});
        end
        m_crc_valid = pre_disp && mh == 639 && mv == 479;
        if (m_crc_valid) m_crc = m_acc;
`endif
        cur = pipe.pop_front();
        pipe.push_back(pin);
        hsf = m_prev_hs && !cur[7];
        vsf = m_prev_vs && !cur[3];
        m_prev_hs = cur[7];
        m_prev_vs = cur[3];
        oh = mh;
        mh = hsf ? 656 : (mh + 1) % 800;
        if (vsf)                  mv = 490;
        else if (!hsf && oh == 799) mv = (mv + 1) % 525;
        good = hsf && oh == 655;
        if (!ml) begin
            lock_now = vsf && gc >= LOCK_LINES;
            if (good)     gc = (gc < LOCK_LINES) ? gc + 1 : gc;
            else if (hsf) gc = 0;
            if (lock_now) begin ml = 1'b1; mc = 0; end
        end else begin
            miss = (hsf && !good) || (!hsf && oh == 655);
            if (miss) begin
                mc++;
                if (mc >= MISS_LIMIT) begin ml = 1'b0; gc = 0; mc = 0; end
            end else if (good) begin
                mc = 0;
            end
        end
        m_pix = cur;
    endtask

    task automatic compare_outputs();
        bit e_disp, e_fs;
        logic [5:0] e_rgb;
        e_disp = ml && mh < 640 && mv < 480;
        e_fs   = ml && mh == 0 && mv == 0;
        e_rgb  = e_disp ? pix_rgb(m_pix) : 6'd0;
        check("pos", {hpos, vpos}, {10'(mh), 10'(mv)});
        check("flags", {locked, display_on, frame_start, r, g, b}, {ml, e_disp, e_fs, e_rgb});
        if (ml && mh == 100 && mv == 1)
            check("pix_100_1", {display_on, r, g, b}, {1'b1, 2'd3, 2'd1, 2'd2});
        if (ml && mh == 700 && mv == 1)
            check("pix_700_1", {display_on, r, g, b}, 7'd0);
`ifdef FRAME_CRC_EN
        check("crc_valid", crc_valid, m_crc_valid);
        if (m_crc_valid) check("crc", crc, m_crc);
`endif
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic run_cycle();
        vga_in = tx_byte();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(vga_in);
        #1;
        compare_outputs();
        fs_seen += int'(frame_start);
        tx_advance();
        @(negedge clk);
    endtask

    task automatic run_lines(input int n);
        repeat (n * line_len) run_cycle();
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        vga_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_pos", {hpos, vpos}, 20'd0);
        check("rst_flags", {locked, display_on, frame_start, r, g, b}, 9'd0);
        reset = 1'b0;

        // Acquire: start 5 lines before vsync, lock exactly at the vsync fall.
        tx_h = 0; tx_v = 485; line_len = 800;
        run_lines(5);
        check("no_early_lock", locked, 1'b0);
        fs_seen = 0;
        run_lines(38);
        check("lock_acq", locked, 1'b1);
        check("frame_start_cnt", fs_seen, 1);

        // Missing hsync: drop after the second missed line, relock after restoring.
        hs_off = 1'b1;
        run_lines(1);
        check("miss1_locked", locked, 1'b1);
        run_lines(1);
        check("miss2_unlocked", locked, 1'b0);
        run_lines(1);
        hs_off = 1'b0;
        tx_v = 485;
        run_lines(6);
        check("relock_miss", locked, 1'b1);

        // Asynchronous reset mid-line.
        repeat (300) run_cycle();
        #2 reset = 1'b1;
        #1;
        check("rst_async", {hpos, vpos, locked, display_on, frame_start, r, g, b}, 29'd0);
        model_reset();
        @(negedge clk);
        repeat (2) run_cycle();
        reset = 1'b0;
        tx_h = 0; tx_v = 485;
        fs_seen = 0;
        run_lines(6);
        check("relock_rst", locked, 1'b1);
        check("no_fs_unlocked", fs_seen, 0);

        // 801-cycle lines: every line bad, never locks across a vsync.
        reset = 1'b1;
        repeat (2) run_cycle();
        reset = 1'b0;
        line_len = 801; tx_h = 0; tx_v = 480;
        run_lines(14);
        check("len801_unlocked", locked, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
